// File: rtl/dmem_pkg.sv
// Shared types and defaults for the parametrised data memory.
// Holds the controller state encoding and the default response record layout.
package dmem_pkg;

    localparam int DMEM_DATA_WIDTH = 16;
    localparam int DMEM_ADDR_WIDTH = 16;
    localparam int DMEM_DEPTH      = 128;
    localparam int DMEM_RD_LATENCY = 1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } dmem_state_t;

    typedef struct packed {
        logic                       valid;
        logic                       err;
        logic [DMEM_DATA_WIDTH-1:0] rdata;
    } dmem_resp_t;

endpackage

// File: rtl/dmem_param_check.sv
// Elaboration-time legality checks for the data memory parameters.
module dmem_param_check #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 128,
    parameter int RD_LATENCY = 1
) ();

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("param_data_memory: RD_LATENCY must be in 1..4");
    end

    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("param_data_memory: DATA_WIDTH must be a multiple of 8");
    end

    if ($clog2(DEPTH) > ADDR_WIDTH) begin : g_bad_depth
        $error("param_data_memory: DEPTH not addressable with ADDR_WIDTH bits");
    end

endmodule

// File: rtl/dmem_resp_pipe.sv
// Fixed-latency response shift register; stage 0 is loaded on the accept edge.
module dmem_resp_pipe #(
    parameter int WIDTH   = 18,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [LATENCY];

    // Shift responses toward the output; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < LATENCY; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[LATENCY-1];

endmodule

// File: rtl/param_data_memory.sv
// Single-port data memory with valid/ready requests, byte-lane writes,
// fixed read latency, range error reporting and a self-timed clear sweep.
module param_data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int DEPTH      = DMEM_DEPTH,
    parameter int RD_LATENCY = DMEM_RD_LATENCY
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_start,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    busy
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so the range check never wraps or truncates DEPTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DATA_WIDTH-1:0] rdata;
    } resp_t;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BE_W-1:0]       be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int k = 0; k < BE_W; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_w[8*k +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    dmem_state_t           state_r;
    dmem_state_t           state_nxt_s;
    logic [PTR_W-1:0]      ptr_r;
    logic [PTR_W-1:0]      ptr_nxt_s;
    logic                  accept_s;
    logic                  in_range_s;
    logic [PTR_W-1:0]      addr_idx_s;
    resp_t                 resp_in_s;
    resp_t                 resp_out_s;

    dmem_param_check #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_param_check ();

    assign req_ready  = (state_r == ST_IDLE) && !clear_start;
    assign busy       = (state_r == ST_CLEAR);
    assign accept_s   = req_valid && req_ready;
    assign in_range_s = ({1'b0, req_addr} < DEPTH_EXT);
    assign addr_idx_s = req_addr[PTR_W-1:0];

    // Controller state and sweep pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_CLEAR;
            ptr_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Next-state logic: the sweep leaves CLEAR on its last word.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            ST_CLEAR: begin
                if (ptr_r == PTR_W'(DEPTH - 1)) begin
                    state_nxt_s = ST_IDLE;
                    ptr_nxt_s   = '0;
                end else begin
                    ptr_nxt_s   = ptr_r + PTR_W'(1);
                end
            end
            ST_IDLE: begin
                if (clear_start) begin
                    state_nxt_s = ST_CLEAR;
                    ptr_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_CLEAR;
                ptr_nxt_s   = '0;
            end
        endcase
    end

    // Array update: sweep writes zero, accepted in-range writes merge lanes.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[ptr_r] <= '0;
        end else if (accept_s && req_we && in_range_s) begin
            mem_r[addr_idx_s] <= merge_bytes(mem_r[addr_idx_s], req_wdata, req_be);
        end
    end

    // Response captured at the accept edge; reads see all earlier writes.
    always_comb begin
        resp_in_s = '0;
        if (accept_s) begin
            resp_in_s.valid = 1'b1;
            resp_in_s.err   = !in_range_s;
            if (in_range_s && !req_we) begin
                resp_in_s.rdata = mem_r[addr_idx_s];
            end else begin
                resp_in_s.rdata = '0;
            end
        end else begin
            resp_in_s = '0;
        end
    end

    dmem_resp_pipe #(
        .WIDTH   ($bits(resp_t)),
        .LATENCY (RD_LATENCY)
    ) u_resp_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (resp_in_s),
        .dout (resp_out_s)
    );

    assign resp_valid = resp_out_s.valid;
    assign resp_err   = resp_out_s.err;
    assign resp_rdata = resp_out_s.rdata;

endmodule

// File: tb/tb_param_data_memory.sv
// Self-checking bench: two instances (read latency 1 and 3) share stimulus and
// are scored every cycle against a word-array reference model.
module tb_param_data_memory;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_start = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [1:0]    req_be = '0;

    logic          rdy1, rv1, err1, busy1;
    logic [DW-1:0] rd1;
    logic          rdy3, rv3, err3, busy3;
    logic [DW-1:0] rd3;

    always #5 clk = ~clk;

    param_data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .clear_start(clear_start), .req_valid(req_valid),
        .req_ready(rdy1), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1), .busy(busy1));

    param_data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .clear_start(clear_start), .req_valid(req_valid),
        .req_ready(rdy3), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3), .busy(busy3));

    typedef struct {
        int            due;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    be;
        logic [DW-1:0] exp_data;
        logic          exp_err;
    } vec_t;

    exp_t          q1[$];
    exp_t          q3[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock: advance, then score both response channels away from the edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (q1.size() > 0 && q1[0].due == cyc) begin
            chk("lat1 resp_valid", 32'(rv1), 32'd1);
            chk("lat1 resp_err", 32'(err1), 32'(q1[0].err));
            chk("lat1 resp_rdata", 32'(rd1), 32'(q1[0].data));
            void'(q1.pop_front());
        end else begin
            chk("lat1 idle resp_valid", 32'(rv1), 32'd0);
        end
        if (q3.size() > 0 && q3[0].due == cyc) begin
            chk("lat3 resp_valid", 32'(rv3), 32'd1);
            chk("lat3 resp_err", 32'(err3), 32'(q3[0].err));
            chk("lat3 resp_rdata", 32'(rd3), 32'(q3[0].data));
            void'(q3.pop_front());
        end else begin
            chk("lat3 idle resp_valid", 32'(rv3), 32'd0);
        end
    endtask

    task automatic push(input logic err, input logic [DW-1:0] data);
        exp_t e;
        e.err  = err;
        e.data = data;
        e.due  = cyc + 1;
        q1.push_back(e);
        e.due  = cyc + 3;
        q3.push_back(e);
    endtask

    // Reference behaviour of one accepted request.
    task automatic model_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                             input logic [1:0] be, output logic err, output logic [DW-1:0] data);
        err  = (int'(addr) >= DEPTH);
        data = '0;
        if (!err) begin
            if (we) begin
                if (be[0]) ref_mem[addr[6:0]][7:0]  = wd[7:0];
                if (be[1]) ref_mem[addr[6:0]][15:8] = wd[15:8];
            end else begin
                data = ref_mem[addr[6:0]];
            end
        end
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [1:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        #1;
        chk("req_ready lat1", 32'(rdy1), 32'd1);
        chk("req_ready lat3", 32'(rdy3), 32'd1);
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [1:0] be);
        logic          e;
        logic [DW-1:0] d;
        drive(we, addr, wd, be);
        model_req(we, addr, wd, be, e, d);
        push(e, d);
        tick();
    endtask

    task automatic nop(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // Count cycles with busy high; a clear_start pulse mid-sweep must be ignored.
    task automatic sweep_len(input string name, input int pulse_at);
        int cnt;
        cnt = 0;
        while (busy1 && cnt < 1000) begin
            chk("req_ready low during sweep", 32'(rdy1), 32'd0);
            chk("busy agree", 32'(busy3), 32'(busy1));
            clear_start = (cnt == pulse_at);
            cnt++;
            tick();
        end
        clear_start = 1'b0;
        chk(name, 32'(cnt), 32'd128);
        chk("req_ready after sweep", 32'(rdy1), 32'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        req_valid = 1'b0;
        q1.delete();
        q3.delete();
        clear_model();
        #1;
        chk("reset busy", 32'(busy1), 32'd1);
        chk("reset req_ready", 32'(rdy1), 32'd0);
        chk("reset resp_valid lat1", 32'(rv1), 32'd0);
        chk("reset resp_valid lat3", 32'(rv3), 32'd0);
        chk("reset resp_rdata", 32'(rd1), 32'd0);
        chk("reset resp_err", 32'(err1), 32'd0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{1'b0, 16'd5,      16'h0000, 2'b11, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 16'd3,      16'hBEEF, 2'b11, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 16'd3,      16'h0000, 2'b00, 16'hBEEF, 1'b0};
        vecs[3]  = '{1'b1, 16'd10,     16'h1234, 2'b11, 16'h0000, 1'b0};
        vecs[4]  = '{1'b1, 16'd10,     16'hAB00, 2'b10, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 16'd10,     16'h0000, 2'b00, 16'hAB34, 1'b0};
        vecs[6]  = '{1'b1, 16'd11,     16'h77CD, 2'b01, 16'h0000, 1'b0};
        vecs[7]  = '{1'b0, 16'd11,     16'h0000, 2'b00, 16'h00CD, 1'b0};
        vecs[8]  = '{1'b1, 16'd12,     16'hFFFF, 2'b00, 16'h0000, 1'b0};
        vecs[9]  = '{1'b0, 16'd12,     16'h0000, 2'b00, 16'h0000, 1'b0};
        vecs[10] = '{1'b1, 16'd200,    16'h5555, 2'b11, 16'h0000, 1'b1};
        vecs[11] = '{1'b0, 16'd200,    16'h0000, 2'b00, 16'h0000, 1'b1};
        vecs[12] = '{1'b0, 16'd128,    16'h0000, 2'b00, 16'h0000, 1'b1};
        vecs[13] = '{1'b1, 16'd127,    16'hC0DE, 2'b11, 16'h0000, 1'b0};
        vecs[14] = '{1'b0, 16'd127,    16'h0000, 2'b00, 16'hC0DE, 1'b0};
        vecs[15] = '{1'b1, 16'h0100,   16'h9999, 2'b11, 16'h0000, 1'b1};
        vecs[16] = '{1'b0, 16'd0,      16'h0000, 2'b00, 16'h0000, 1'b0};
        vecs[17] = '{1'b0, 16'hFFFF,   16'h0000, 2'b00, 16'h0000, 1'b1};

        #1;
        apply_reset();
        sweep_len("power-up sweep length", -1);

        // Directed vectors, back to back.
        for (int i = 0; i < 18; i++) begin
            logic          e;
            logic [DW-1:0] d;
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            model_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, e, d);
            push(vecs[i].exp_err, vecs[i].exp_data);
            tick();
        end
        nop(4);

        // Whole array unchanged by the out-of-range accesses.
        for (int a = 0; a < DEPTH; a++) issue(1'b0, AW'(a), 16'h0000, 2'b00);
        nop(4);

        // Preload 1..4 then four back-to-back reads.
        for (int a = 0; a < 4; a++) issue(1'b1, AW'(a), DW'(a + 1), 2'b11);
        for (int a = 0; a < 4; a++) issue(1'b0, AW'(a), 16'h0000, 2'b00);
        nop(5);

        // Randomised traffic with idle gaps and occasional out-of-range addresses.
        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] ra;
            ra = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(128, 65535))
                                             : AW'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) begin
                issue(1'($urandom_range(0, 1)), ra, DW'($urandom), 2'($urandom_range(0, 3)));
            end else begin
                req_addr = ra;
                nop(1);
            end
        end
        nop(4);

        // Clear command with a read still in flight; request in the clear cycle is refused.
        issue(1'b1, 16'd7, 16'h00FF, 2'b11);
        issue(1'b0, 16'd7, 16'h0000, 2'b00);
        clear_start = 1'b1;
        req_valid   = 1'b1;
        req_we      = 1'b0;
        req_addr    = 16'd7;
        #1;
        chk("req_ready with clear_start lat1", 32'(rdy1), 32'd0);
        chk("req_ready with clear_start lat3", 32'(rdy3), 32'd0);
        tick();
        clear_start = 1'b0;
        req_valid   = 1'b0;
        clear_model();
        sweep_len("clear sweep length", 50);
        issue(1'b0, 16'd7, 16'h0000, 2'b00);
        nop(4);

        // Reset while a latency-3 response is in flight drops it.
        issue(1'b0, 16'd5, 16'h0000, 2'b00);
        apply_reset();
        chk("dropped lat3 resp_valid", 32'(rv3), 32'd0);

        // Reset 40 cycles into the sweep restarts it from the beginning.
        repeat (40) begin
            chk("busy before mid-sweep reset", 32'(busy1), 32'd1);
            tick();
        end
        apply_reset();
        sweep_len("restarted sweep length", -1);
        issue(1'b0, 16'd3, 16'h0000, 2'b00);
        nop(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/param_data_memory.md
Name: param_data_memory

Overview:
- Parametrised single-port data memory for the 16-bit processor datapath, replacing the fixed 128x16 RAM.
- Adds a valid/ready request handshake, byte-lane write enables, a configurable read pipeline latency and out-of-range error reporting.
- Clears the array with a self-timed sweep after reset or on command, instead of clearing every word in a single reset cycle.
- Sits between the load/store unit and the data address space.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 16, request address width in bits.
- DEPTH, 128, number of words; valid word addresses are 0..DEPTH-1.
- RD_LATENCY, 1, cycles from request acceptance to resp_valid; legal range 1..4.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear_start  in  1  one-cycle pulse that starts a full-array clear sweep.
- req_valid  in  1  a request is present on the req_* inputs.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  DATA_WIDTH/8  byte-lane write enables; bit k selects bits [8k+7:8k].
- resp_valid  out  1  one-cycle response strobe, one per accepted request.
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errors.
- resp_err  out  1  the accepted address was >= DEPTH.
- busy  out  1  a clear sweep is in progress.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to CLEAR with the sweep pointer at 0.
  - busy=1, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - The response pipeline is flushed.
  - Array contents are not reset directly; the sweep clears them.
- FSM states and transitions:
  - CLEAR: each cycle writes 0 to word[ptr] and increments ptr. In the cycle ptr==DEPTH-1, move to IDLE, so a full sweep takes exactly DEPTH cycles.
  - IDLE: req_ready=1, busy=0. If clear_start=1 (with or without a request), move to CLEAR with ptr=0; any request in that cycle is not accepted.
  - In CLEAR, clear_start is ignored and the sweep is not restarted.
- req_ready = (state==IDLE) && !clear_start. This is the only combinational path from input to output.
- Acceptance happens on a rising edge where req_valid && req_ready.
- Write acceptance:
  - If req_addr < DEPTH, each lane with req_be[k]=1 takes req_wdata at that edge. Lanes with req_be[k]=0 are unchanged.
  - If req_be is all zero, nothing is modified, but a response is still produced.
- Read acceptance: word[req_addr] is sampled at the accept edge. A read accepted the cycle after a write to the same address returns the new data; there is no stale window.
- Out-of-range addresses (req_addr >= DEPTH, compared at full ADDR_WIDTH with no wrap or truncation):
  - No array access.
  - The response has resp_err=1 and resp_rdata=0.
- Response timing:
  - Every accepted request produces exactly one resp_valid pulse, exactly RD_LATENCY cycles after its accept edge.
  - Responses come back in order. The pipeline is a shift of RD_LATENCY stages holding {valid, err, data}.
  - resp_* outputs are registered.
  - The response channel has no backpressure.
- Throughput: one request per cycle, back-to-back in IDLE.
- clear_start while responses are in flight: the in-flight responses still complete with the data they already captured.
- rst asserted mid-sweep or mid-response: all in-flight responses are dropped and the sweep restarts from 0.
- Simulation assertions:
  - RD_LATENCY outside 1..4 or DATA_WIDTH%8 != 0 → $error.
  - $clog2(DEPTH) > ADDR_WIDTH → $error.

Decomposition:
- Shared package (dmem_pkg):
  - FSM state enum (ST_CLEAR, ST_IDLE).
  - Default width/depth constants.
  - Response struct {valid, err, rdata}.
- One sub-module, dmem_resp_pipe: parametrised RD_LATENCY shift register for the response struct, with async active-low clear. The array, handshake and FSM stay in the top module.

Test Plan:
- Reset sequence: release rst → busy=1 and req_ready=0 for exactly 128 cycles, then req_ready=1. A read of addr 5 returns resp_rdata=16'h0000, err=0.
- Write then read, RD_LATENCY=1: write 16'hBEEF to addr 3 with be=2'b11, then read addr 3 next cycle → resp_valid one cycle after each accept, and the read returns 16'hBEEF.
- Byte enables: write 16'h1234 with be=11, then 16'hAB00 with be=10, then read → 16'hAB34.
- Out of range: write 16'h5555 to addr 200, then read addr 200 → both responses have err=1, rdata=0. Reads of addrs 0..127 are unchanged.
- Latency and throughput with RD_LATENCY=3: 4 back-to-back reads of addrs 0..3 preloaded with 1,2,3,4 → resp_valid on 4 consecutive cycles starting 3 cycles after the first accept, with data 1,2,3,4 in order.
- Clear command: write 16'h00FF to addr 7, pulse clear_start → req_ready=0 for 128 cycles, then reading addr 7 returns 0. Asserting rst mid-sweep at cycle 40 restarts a full 128-cycle sweep.
